load_store_unit: RTL and testbench

Parametrised multi-cycle load/store unit that replaces the core's single-cycle combinational memory path for LB/LH/LW/LBU/LHU/SB/SH/SW. It sits between the execute stage and the unified data memory. It accepts one request at a time over a valid/ready handshake and drives a byte-strobed, bus-width-aligned memory port. It adds 64-bit bus support, misaligned-access splitting and an explicit error response, none of which the current core has.

---
 rtl/load_store_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one load or store, drives a
// byte-strobed bus-aligned memory port (one or two beats) and returns an
// extended load result or an error pulse.
module load_store_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state, state_n;

  // Registered outputs and their next values
  logic              mem_valid_n, mem_we_n, rsp_valid_n, rsp_err_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [XLEN-1:0]   mem_wdata_n, rsp_rdata_n;
  logic [NB-1:0]     mem_wstrb_n;

  // Request decode
  logic              dec_legal, dec_sgn, dec_split, dec_err;
  logic [3:0]        dec_size;
  logic [OFF_W-1:0]  dec_off;
  int                dec_end;
  logic [2*NB-1:0]   dec_strb;
  logic [2*XLEN-1:0] dec_wdata;

  // Latched request fields; second-beat lanes are precomputed at accept
  logic              we_q, sgn_q, split_q;
  logic [3:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [XLEN-1:0]   wdata_hi_q, rdata0_q;
  logic [NB-1:0]     strb_hi_q;

  logic              accept, capture0;
  logic [2*XLEN-1:0] rd_cat;
  logic [XLEN-1:0]   rd_low, rd_ext;

  // Keep the low size bytes of raw and fill the rest with the sign or zero
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input logic [3:0] size,
                                             input logic sgn);
    logic [XLEN-1:0] r;
    logic            sb;
    sb = 1'b0;
    for (int i = 0; i < NB; i++)
      if (sgn && (i == int'(size) - 1)) sb = raw[8*i+7];
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = (i < int'(size)) ? raw[8*i +: 8] : {8{sb}};
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] aligned(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  assign req_ready = (state == IDLE) && nreset;

  // Decode size/sign/legality and lay the request out across two beats
  always_comb begin
    dec_legal = 1'b0;
    dec_sgn   = 1'b0;
    dec_size  = 4'd1;
    if (req_we) begin
      case (req_funct3)
        3'b000:  begin dec_legal = 1'b1;         dec_size = 4'd1; end
        3'b001:  begin dec_legal = 1'b1;         dec_size = 4'd2; end
        3'b010:  begin dec_legal = 1'b1;         dec_size = 4'd4; end
        3'b011:  begin dec_legal = (XLEN == 64); dec_size = 4'd8; end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  begin dec_legal = 1'b1;         dec_size = 4'd1; dec_sgn = 1'b1; end
        3'b001:  begin dec_legal = 1'b1;         dec_size = 4'd2; dec_sgn = 1'b1; end
        3'b010:  begin dec_legal = 1'b1;         dec_size = 4'd4; dec_sgn = 1'b1; end
        3'b011:  begin dec_legal = (XLEN == 64); dec_size = 4'd8; dec_sgn = 1'b1; end
        3'b100:  begin dec_legal = 1'b1;         dec_size = 4'd1; end
        3'b101:  begin dec_legal = 1'b1;         dec_size = 4'd2; end
        3'b110:  begin dec_legal = (XLEN == 64); dec_size = 4'd4; end
        default: dec_legal = 1'b0;
      endcase
    end
    dec_off   = req_addr[OFF_W-1:0];
    dec_end   = int'(dec_off) + int'(dec_size);
    dec_split = (dec_end > NB);
    dec_err   = !dec_legal || (dec_split && (SPLIT_MISALIGNED == 0));
    for (int i = 0; i < 2*NB; i++)
      dec_strb[i] = (i >= int'(dec_off)) && (i < dec_end);
    dec_wdata = {{XLEN{1'b0}}, req_wdata} << (8 * int'(dec_off));
  end

  // Merge beats, shift the addressed bytes down and extend
  always_comb begin
    rd_cat = split_q ? {mem_rdata, rdata0_q} : {{XLEN{1'b0}}, mem_rdata};
    rd_low = XLEN'(rd_cat >> (8 * int'(off_q)));
    rd_ext = extend(rd_low, size_q, sgn_q);
  end

  // Next state and next registered outputs
  always_comb begin
    state_n     = state;
    mem_valid_n = mem_valid;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_wstrb_n = mem_wstrb;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_rdata_n = rsp_rdata;
    accept      = 1'b0;
    capture0    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (dec_err) begin
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end else begin
            state_n     = BEAT0;
            mem_valid_n = 1'b1;
            mem_we_n    = req_we;
            mem_addr_n  = aligned(req_addr);
            mem_wdata_n = dec_wdata[XLEN-1:0];
            mem_wstrb_n = req_we ? dec_strb[NB-1:0] : {NB{1'b1}};
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          capture0 = 1'b1;
          if (split_q) begin
            state_n     = BEAT1;
            mem_addr_n  = mem_addr + ADDR_W'(NB);
            mem_wdata_n = wdata_hi_q;
            mem_wstrb_n = we_q ? strb_hi_q : {NB{1'b1}};
          end else begin
            state_n     = IDLE;
            mem_valid_n = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_rdata_n = we_q ? '0 : rd_ext;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_n     = IDLE;
          mem_valid_n = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = we_q ? '0 : rd_ext;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and output registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      mem_valid <= mem_valid_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_wstrb <= mem_wstrb_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

  // Request fields and first-beat read data; only meaningful outside IDLE
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q       <= req_we;
      sgn_q      <= dec_sgn;
      size_q     <= dec_size;
      off_q      <= dec_off;
      split_q    <= dec_split;
      wdata_hi_q <= dec_wdata[2*XLEN-1:XLEN];
      strb_hi_q  <= dec_strb[2*NB-1:NB];
    end
    if (capture0) rdata0_q <= mem_rdata;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: three instances (32-bit splitting, 32-bit
// non-splitting, 64-bit splitting) driven by directed requests; expected
// beats and responses are queued and checked by a negedge monitor.
module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
  } beat_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
    string       name;
  } rsp_t;

  logic clk = 1'b0;
  logic nreset;
  logic [2:0]       req_valid, req_we, mem_ready;
  logic [2:0][2:0]  req_funct3;
  logic [2:0][31:0] req_addr;
  logic [2:0][63:0] req_wdata, mem_rdata;
  wire  [2:0]       req_ready, rsp_valid, rsp_err, mem_valid, mem_we;
  wire  [2:0][63:0] rsp_rdata, mem_wdata;
  wire  [2:0][31:0] mem_addr;
  wire  [2:0][7:0]  mem_wstrb;

  beat_t beat_q[3][$];
  rsp_t  rsp_q[3][$];
  int    stall[3];
  int    cyc;
  int    checks;
  int    errors;
  beat_t mb;
  rsp_t  mr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int XL  = (g == 2) ? 64 : 32;
    localparam int NBL = XL / 8;
    load_store_unit #(.XLEN(XL), .ADDR_W(32), .SPLIT_MISALIGNED((g == 1) ? 0 : 1)) u_dut (
      .clk(clk), .nreset(nreset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_funct3(req_funct3[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g][XL-1:0]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g][XL-1:0]), .rsp_err(rsp_err[g]),
      .mem_valid(mem_valid[g]), .mem_ready(mem_ready[g]), .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g][XL-1:0]),
      .mem_wstrb(mem_wstrb[g][NBL-1:0]), .mem_rdata(mem_rdata[g][XL-1:0]));
    if (XL < 64) begin : g_pad
      assign rsp_rdata[g][63:XL] = '0;
      assign mem_wdata[g][63:XL] = '0;
      assign mem_wstrb[g][7:NBL] = '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: answers in the same cycle after the programmed stall
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 3; g++) begin
      mem_ready[g] = 1'b0;
      mem_rdata[g] = '0;
      if (mem_valid[g]) begin
        if (stall[g] > 0) stall[g]--;
        else mem_ready[g] = 1'b1;
        if (beat_q[g].size() > 0) mem_rdata[g] = beat_q[g][0].rdata;
      end
    end
  end

  // Monitor: memory beats (every cycle mem_valid is high) and responses
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (mem_valid[g]) begin
        if (beat_q[g].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat dut%0d: mem_valid=1 at addr 0x%0h, required no beat", g, mem_addr[g]);
        end else begin
          mb = beat_q[g][0];
          chk($sformatf("dut%0d_beat_addr", g), 64'(mem_addr[g]), 64'(mb.addr));
          chk($sformatf("dut%0d_beat_we", g), 64'(mem_we[g]), 64'(mb.we));
          chk($sformatf("dut%0d_beat_wstrb", g), 64'(mem_wstrb[g]), 64'(mb.wstrb));
          if (mb.we) chk($sformatf("dut%0d_beat_wdata", g), mem_wdata[g], mb.wdata);
          if (mem_ready[g]) void'(beat_q[g].pop_front());
        end
      end
      if (rsp_valid[g]) begin
        if (rsp_q[g].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp dut%0d: rsp_valid=1 rdata 0x%0h, required none", g, rsp_rdata[g]);
        end else begin
          mr = rsp_q[g].pop_front();
          chk({mr.name, "_rdata"}, rsp_rdata[g], mr.rdata);
          chk({mr.name, "_err"}, 64'(rsp_err[g]), 64'(mr.err));
          chk({mr.name, "_cycle"}, 64'(cyc), 64'(mr.due));
          chk({mr.name, "_ready_with_rsp"}, 64'(req_ready[g]), 64'd1);
        end
      end else if (rsp_q[g].size() > 0 && cyc > rsp_q[g][0].due) begin
        mr = rsp_q[g].pop_front();
        checks++; errors++;
        $display("FAIL %s_timeout: no rsp_valid by cycle %0d, required at cycle %0d", mr.name, cyc, mr.due);
      end
    end
  end

  task automatic beat(input int g, input logic we, input logic [31:0] a, input logic [63:0] wd,
                      input logic [7:0] st, input logic [63:0] rd);
    beat_t b;
    b.we = we; b.addr = a; b.wdata = wd; b.wstrb = st; b.rdata = rd;
    beat_q[g].push_back(b);
  endtask

  // Present a request; lat < 0 means no response is expected
  task automatic issue(input int g, input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] exp_rd,
                       input logic exp_err, input int lat, input int stl);
    rsp_t r;
    int   n;
    n = 0;
    stall[g] = stl;
    req_valid[g] = 1'b1; req_we[g] = we; req_funct3[g] = f3; req_addr[g] = a; req_wdata[g] = wd;
    @(negedge clk);
    while (!req_ready[g] && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready[g]) begin
      errors++;
      $display("FAIL %s_accept: req_ready 0 after %0d cycles, required 1", name, n);
    end else if (lat >= 0) begin
      r.rdata = exp_rd; r.err = exp_err; r.due = cyc + lat; r.name = name;
      rsp_q[g].push_back(r);
    end
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while ((rsp_q[g].size() != 0 || beat_q[g].size() != 0) && n < 60) begin @(negedge clk); n++; end
    if (rsp_q[g].size() != 0 || beat_q[g].size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_dut%0d: %0d rsp and %0d beats outstanding, required 0", g, rsp_q[g].size(), beat_q[g].size());
      rsp_q[g].delete(); beat_q[g].delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0;
    req_valid = '0; req_we = '0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int g = 0; g < 3; g++) stall[g] = 0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_ctrl_dut%0d", g),
          64'({req_ready[g], rsp_valid[g], rsp_err[g], mem_valid[g], mem_we[g], mem_wstrb[g], mem_addr[g]}), 64'd0);
      chk($sformatf("reset_rdata_dut%0d", g), rsp_rdata[g], 64'd0);
      chk($sformatf("reset_wdata_dut%0d", g), mem_wdata[g], 64'd0);
    end
    @(posedge clk); #1 nreset = 1'b1;
    @(posedge clk); #1;

    // 32-bit, splitting
    beat(0, 0, 32'h100, 0, 8'h0F, 64'hDEADBEEF);
    issue(0, "lw_100", 0, 3'b010, 32'h100, 0, 64'hDEADBEEF, 0, 2, 0); drain(0);
    beat(0, 0, 32'h100, 0, 8'h0F, 64'h80000000);
    issue(0, "lb_103", 0, 3'b000, 32'h103, 0, 64'hFFFFFF80, 0, 2, 0); drain(0);
    beat(0, 0, 32'h100, 0, 8'h0F, 64'h80000000);
    issue(0, "lbu_103", 0, 3'b100, 32'h103, 0, 64'h00000080, 0, 2, 0); drain(0);
    beat(0, 1, 32'h100, 64'hABCD0000, 8'h0C, 0);
    issue(0, "sh_102", 1, 3'b001, 32'h102, 64'h1234ABCD, 0, 0, 2, 0); drain(0);
    beat(0, 0, 32'h0FC, 0, 8'h0F, 64'h11223344);
    beat(0, 0, 32'h100, 0, 8'h0F, 64'h55667788);
    issue(0, "lw_split_0fe", 0, 3'b010, 32'h0FE, 0, 64'h77881122, 0, 3, 0); drain(0);
    beat(0, 1, 32'h0FC, 64'hCCDD0000, 8'h0C, 0);
    beat(0, 1, 32'h100, 64'h0000AABB, 8'h03, 0);
    issue(0, "sw_split_0fe", 1, 3'b010, 32'h0FE, 64'hAABBCCDD, 0, 0, 3, 0); drain(0);
    beat(0, 0, 32'hFFFFFFFC, 0, 8'h0F, 64'h11223344);
    beat(0, 0, 32'h00000000, 0, 8'h0F, 64'h55667788);
    issue(0, "lw_wrap", 0, 3'b010, 32'hFFFFFFFE, 0, 64'h77881122, 0, 3, 0); drain(0);
    beat(0, 0, 32'h200, 0, 8'h0F, 64'h80011234);
    issue(0, "lh_stall5", 0, 3'b001, 32'h202, 0, 64'hFFFF8001, 0, 7, 5); drain(0);
    issue(0, "ld_on_rv32", 0, 3'b011, 32'h100, 0, 0, 1, 1, 0); drain(0);
    issue(0, "store_f3_100", 1, 3'b100, 32'h100, 64'h55, 0, 1, 1, 0); drain(0);
    beat(0, 0, 32'h104, 0, 8'h0F, 64'h89AB0000);
    issue(0, "lhu_106_b2b", 0, 3'b101, 32'h106, 0, 64'h000089AB, 0, 2, 0);
    beat(0, 1, 32'h104, 64'h00005A00, 8'h02, 0);
    issue(0, "sb_105_b2b", 1, 3'b000, 32'h105, 64'h0000005A, 0, 0, 2, 0); drain(0);

    // Reset while a beat is stalled: transaction is abandoned
    beat(0, 0, 32'h300, 0, 8'h0F, 64'h0);
    issue(0, "abandon", 0, 3'b010, 32'h300, 0, 0, 0, -1, 100);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 nreset = 1'b0;
    @(negedge clk);
    chk("abandon_ready_in_reset", 64'(req_ready[0]), 64'd0);
    @(negedge clk);
    chk("abandon_mem_valid", 64'(mem_valid[0]), 64'd0);
    beat_q[0].delete(); stall[0] = 0;
    @(posedge clk); #1 nreset = 1'b1;
    @(negedge clk);
    chk("abandon_ready_after", 64'(req_ready[0]), 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    beat(0, 0, 32'h100, 0, 8'h0F, 64'h13579BDF);
    issue(0, "lw_after_reset", 0, 3'b010, 32'h100, 0, 64'h13579BDF, 0, 2, 0); drain(0);

    // 32-bit, no splitting
    issue(1, "lw_0fe_nosplit", 0, 3'b010, 32'h0FE, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("nosplit_mem_valid", 64'(mem_valid[1]), 64'd0);
    drain(1);
    beat(1, 0, 32'h100, 0, 8'h0F, 64'hCAFEF00D);
    issue(1, "lw_100_nosplit", 0, 3'b010, 32'h100, 0, 64'hCAFEF00D, 0, 2, 0); drain(1);
    issue(1, "f3_011_rv32", 0, 3'b011, 32'h100, 0, 0, 1, 1, 0); drain(1);

    // 64-bit
    beat(2, 0, 32'h8, 0, 8'hFF, 64'h0123456789ABCDEF);
    issue(2, "ld_8", 0, 3'b011, 32'h8, 0, 64'h0123456789ABCDEF, 0, 2, 0); drain(2);
    beat(2, 0, 32'h8, 0, 8'hFF, 64'h80000000_00000000);
    issue(2, "lw_c_64", 0, 3'b010, 32'hC, 0, 64'hFFFFFFFF80000000, 0, 2, 0); drain(2);
    beat(2, 0, 32'h8, 0, 8'hFF, 64'h80000000_00000000);
    issue(2, "lwu_c_64", 0, 3'b110, 32'hC, 0, 64'h0000000080000000, 0, 2, 0); drain(2);
    beat(2, 1, 32'h8,  64'h55667788_00000000, 8'hF0, 0);
    beat(2, 1, 32'h10, 64'h00000000_11223344, 8'h0F, 0);
    issue(2, "sd_split_c", 1, 3'b011, 32'hC, 64'h1122334455667788, 0, 0, 3, 0); drain(2);
    issue(2, "f3_111_64", 0, 3'b111, 32'h8, 0, 0, 1, 1, 0); drain(2);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
